// File: rtl/rdma_unpack_if.sv
// AXI-Stream style beat bundle shared by the RDMA unpack input and output.
// master drives the beat; slave returns the ready.
interface rdma_unpack_if #(
  parameter int STREAM_WB = 64
);
  logic [STREAM_WB*8-1:0] TDATA;
  logic [STREAM_WB-1:0]   TKEEP;
  logic                   TVALID;
  logic                   TLAST;
  logic                   TREADY;

  modport master (
    output TDATA, TKEEP, TVALID, TLAST,
    input  TREADY
  );

  modport slave (
    input  TDATA, TKEEP, TVALID, TLAST,
    output TREADY
  );
endinterface

// File: rtl/rdma_unpack.sv
// RDMA unpacker: emits the header as its own beat, then realigns the
// payload so payload byte 0 lands in output byte 0.
module rdma_unpack #(
  parameter int STREAM_WB    = 64,
  parameter int RDMA_HDR_LEN = 51
) (
  input  logic          clk,
  input  logic          resetn,
  rdma_unpack_if.slave  AXIS_RX,
  rdma_unpack_if.master AXIS_TX
);
  localparam int REM = STREAM_WB - RDMA_HDR_LEN;
  localparam int HB  = RDMA_HDR_LEN * 8;
  localparam int RB  = REM * 8;
  localparam int DW  = STREAM_WB * 8;

  typedef enum logic [1:0] {
    INIT,
    HDR,
    DATA,
    FLUSH
  } state_t;

  state_t               state, state_n;
  logic [RB-1:0]        carry_data;
  logic [REM-1:0]       carry_keep;
  logic                 load;
  logic                 rx_hs;
  logic                 hi_zero;
  logic                 rx_ready;
  logic                 tx_valid;
  logic                 tx_last;
  logic [DW-1:0]        tx_data;
  logic [STREAM_WB-1:0] tx_keep;

  assign rx_hs   = AXIS_RX.TVALID & AXIS_TX.TREADY;
  assign hi_zero = AXIS_RX.TKEEP[RDMA_HDR_LEN +: REM] == '0;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= INIT;
      carry_data <= '0;
      carry_keep <= '0;
    end else begin
      state <= state_n;
      if (load) begin
        carry_data <= AXIS_RX.TDATA[HB +: RB];
        carry_keep <= AXIS_RX.TKEEP[RDMA_HDR_LEN +: REM];
      end
    end
  end

  always_comb begin
    state_n  = state;
    load     = 1'b0;
    rx_ready = 1'b0;
    tx_valid = 1'b0;
    tx_last  = 1'b0;
    tx_data  = '0;
    tx_keep  = '0;
    unique case (state)
      INIT: begin
        state_n = HDR;
      end
      HDR: begin
        rx_ready = AXIS_TX.TREADY;
        tx_valid = AXIS_RX.TVALID;
        tx_data  = {{RB{1'b0}}, AXIS_RX.TDATA[HB-1:0]};
        tx_keep  = {{REM{1'b0}}, {RDMA_HDR_LEN{1'b1}}};
        tx_last  = AXIS_RX.TVALID & AXIS_RX.TLAST & hi_zero;
        if (rx_hs) begin
          load = 1'b1;
          if (!AXIS_RX.TLAST) state_n = DATA;
          else if (!hi_zero)  state_n = FLUSH;
        end
      end
      DATA: begin
        rx_ready = AXIS_TX.TREADY;
        tx_valid = AXIS_RX.TVALID;
        tx_data  = {AXIS_RX.TDATA[HB-1:0], carry_data};
        tx_keep  = {AXIS_RX.TKEEP[RDMA_HDR_LEN-1:0], carry_keep};
        tx_last  = AXIS_RX.TVALID & AXIS_RX.TLAST & hi_zero;
        if (rx_hs) begin
          load = 1'b1;
          if (AXIS_RX.TLAST) state_n = hi_zero ? HDR : FLUSH;
        end
      end
      FLUSH: begin
        tx_valid = 1'b1;
        tx_data  = {{HB{1'b0}}, carry_data};
        tx_keep  = {{RDMA_HDR_LEN{1'b0}}, carry_keep};
        tx_last  = 1'b1;
        if (AXIS_TX.TREADY) state_n = HDR;
      end
      default: state_n = INIT;
    endcase
    // Idle beats never expose stale data.
    if (!tx_valid) begin
      tx_data = '0;
      tx_keep = '0;
    end
  end

  assign AXIS_RX.TREADY = rx_ready;
  assign AXIS_TX.TVALID = tx_valid;
  assign AXIS_TX.TLAST  = tx_last;
  assign AXIS_TX.TDATA  = tx_data;
  assign AXIS_TX.TKEEP  = tx_keep;
endmodule

// File: tb/tb_rdma_unpack.sv
// Bench for rdma_unpack: directed corner packets, reset cases, then
// random packets with bubbles and backpressure against a byte model.
module tb_rdma_unpack;
  localparam int WB = 64;
  localparam int HL = 51;
  localparam int DW = WB * 8;
  localparam int CW = DW + WB + 2;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [WB-1:0] k;
    logic          l;
  } beat_t;

  logic clk = 1'b0;
  logic resetn;
  int tests = 0;
  int failed = 0;

  byte unsigned pk[$];
  beat_t exp_q[$];

  rdma_unpack_if #(.STREAM_WB(WB)) AXIS_RX();
  rdma_unpack_if #(.STREAM_WB(WB)) AXIS_TX();

  rdma_unpack #(
    .STREAM_WB(WB),
    .RDMA_HDR_LEN(HL)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .AXIS_RX(AXIS_RX),
    .AXIS_TX(AXIS_TX)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [CW-1:0] obs,
                     input logic [CW-1:0] req);
    tests++;
    assert (obs === req) else begin
      failed++;
      $error("FAIL %s: got %h expected %h", tag, obs, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic make_pkt(input int n);
    pk.delete();
    for (int i = 0; i < n; i++) pk.push_back(8'($urandom));
  endtask

  // Reference: header bytes as one beat, payload cut into
  // full-width chunks starting at output byte 0.
  function automatic void build_exp();
    int p;
    beat_t b;
    p = pk.size() - HL;
    exp_q.delete();
    b = '0;
    for (int i = 0; i < HL; i++) begin
      b.d[i*8 +: 8] = pk[i];
      b.k[i] = 1'b1;
    end
    b.l = (p == 0);
    exp_q.push_back(b);
    for (int s = 0; s < p; s += WB) begin
      b = '0;
      for (int i = 0; i < WB && s + i < p; i++) begin
        b.d[i*8 +: 8] = pk[HL + s + i];
        b.k[i] = 1'b1;
      end
      b.l = (s + WB >= p);
      exp_q.push_back(b);
    end
  endfunction

  function automatic beat_t in_beat(input int i);
    beat_t b;
    int nb;
    nb = (pk.size() + WB - 1) / WB;
    b = '0;
    for (int j = 0; j < WB; j++) begin
      if (i * WB + j < pk.size()) begin
        b.d[j*8 +: 8] = pk[i*WB + j];
        b.k[j] = 1'b1;
      end
    end
    b.l = (i == nb - 1);
    return b;
  endfunction

  task automatic rx_idle();
    AXIS_RX.TVALID = 1'b0;
    AXIS_RX.TLAST  = 1'b0;
    AXIS_RX.TDATA  = '0;
    AXIS_RX.TKEEP  = '0;
  endtask

  task automatic rx_put(input beat_t b);
    AXIS_RX.TVALID = 1'b1;
    AXIS_RX.TDATA  = b.d;
    AXIS_RX.TKEEP  = b.k;
    AXIS_RX.TLAST  = b.l;
  endtask

  task automatic drive(input bit rnd);
    int nb;
    int cyc;
    bit hs;
    nb = (pk.size() + WB - 1) / WB;
    for (int i = 0; i < nb; i++) begin
      if (rnd) begin
        for (int g = 0; g < 3; g++) begin
          if ($urandom_range(0, 2) == 0) begin
            AXIS_RX.TVALID = 1'b0;
            step();
          end
        end
      end
      rx_put(in_beat(i));
      hs = 1'b0;
      cyc = 0;
      while (!hs && cyc < 2000) begin
        @(negedge clk);
        hs = AXIS_RX.TREADY;
        step();
        cyc++;
      end
    end
    rx_idle();
  endtask

  task automatic monitor(input bit rnd);
    int got;
    int cyc;
    bit stall;
    beat_t cur;
    beat_t prev;
    got = 0;
    cyc = 0;
    stall = 1'b0;
    prev = '0;
    AXIS_TX.TREADY = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    while (got < exp_q.size() && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      cur = {AXIS_TX.TDATA, AXIS_TX.TKEEP, AXIS_TX.TLAST};
      if (stall)
        chk("stall_hold", {AXIS_TX.TVALID, cur}, {1'b1, prev});
      stall = AXIS_TX.TVALID && !AXIS_TX.TREADY;
      prev = cur;
      if (AXIS_TX.TVALID && AXIS_TX.TREADY) begin
        chk($sformatf("beat%0d", got), cur, exp_q[got]);
        got++;
      end
      step();
      AXIS_TX.TREADY = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    end
    if (got < exp_q.size())
      chk("out_timeout", got, exp_q.size());
  endtask

  task automatic run_pkt(input int n, input bit rnd);
    make_pkt(n);
    build_exp();
    fork
      drive(rnd);
      monitor(rnd);
    join
    AXIS_TX.TREADY = 1'b1;
    @(negedge clk);
    chk("idle_after", AXIS_TX.TVALID, 0);
    step();
  endtask

  task automatic do_reset();
    AXIS_TX.TREADY = 1'b1;
    AXIS_RX.TVALID = 1'b1;
    AXIS_RX.TLAST  = 1'b1;
    AXIS_RX.TKEEP  = '1;
    AXIS_RX.TDATA  = '1;
    resetn = 1'b0;
    #1;
    chk("rst_tvalid", AXIS_TX.TVALID, 0);
    chk("rst_tlast", AXIS_TX.TLAST, 0);
    chk("rst_tdata", AXIS_TX.TDATA, 0);
    chk("rst_tkeep", AXIS_TX.TKEEP, 0);
    chk("rst_rready", AXIS_RX.TREADY, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rx_idle();
    resetn = 1'b1;
    #1;
    chk("init_rready", AXIS_RX.TREADY, 0);
    step();
    chk("hdr_rready", AXIS_RX.TREADY, 1);
  endtask

  initial begin
    resetn = 1'b1;
    rx_idle();
    AXIS_TX.TREADY = 1'b1;
    #2;
    do_reset();

    run_pkt(HL, 1'b0);
    run_pkt(HL + 5, 1'b0);
    run_pkt(HL + 13 + 64 + 10, 1'b0);
    run_pkt(HL + 13 + 64 + 60, 1'b0);
    run_pkt(WB, 1'b0);
    run_pkt(WB + HL, 1'b0);

    // Reset in the middle of a multi-beat packet.
    make_pkt(200);
    rx_put(in_beat(0));
    @(negedge clk);
    chk("md_hdr_valid", AXIS_TX.TVALID, 1);
    step();
    rx_put(in_beat(1));
    @(negedge clk);
    chk("md_data_valid", AXIS_TX.TVALID, 1);
    #2;
    do_reset();
    run_pkt(120, 1'b0);
    run_pkt(HL + 7, 1'b0);

    for (int i = 0; i < 1000; i++)
      run_pkt($urandom_range(HL, 320), 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule

// File: doc/rdma_unpack.md
RDMA_UNPACK -- requirements
Module: rdma_unpack

Interface
REQ-001 Parameter STREAM_WB, default 64, stream width in bytes.
REQ-002 Parameter RDMA_HDR_LEN, default 51, RDMA header length in bytes; REMAINING_LEN = STREAM_WB - RDMA_HDR_LEN (13 at defaults).
REQ-003 clk  input  1  single clock; all state SHALL change on its rising edge.
REQ-004 resetn  input  1  asynchronous, active-low reset.
REQ-005 AXIS_RX_TDATA  input  STREAM_WB*8  packed input data: header in the low RDMA_HDR_LEN bytes of the first beat, payload contiguous after it.
REQ-006 AXIS_RX_TKEEP  input  STREAM_WB  input byte enables, contiguous from bit 0.
REQ-007 AXIS_RX_TVALID, AXIS_RX_TLAST  input  1 each; AXIS_RX_TREADY  output  1.
REQ-008 AXIS_TX_TDATA  output  STREAM_WB*8; AXIS_TX_TKEEP  output  STREAM_WB; AXIS_TX_TVALID, AXIS_TX_TLAST  output  1 each; AXIS_TX_TREADY  input  1.

Function
REQ-009 Output per packet SHALL be one header beat, then payload beats realigned so payload byte 0 sits in output byte 0.
REQ-010 States: INIT, HDR, DATA, FLUSH; resetn low forces INIT; INIT -> HDR unconditionally on the next clock.
REQ-011 In INIT: AXIS_RX_TREADY=0, AXIS_TX_TVALID=0, TLAST=0, TDATA=0, TKEEP=0.
REQ-012 HDR: AXIS_RX_TREADY = AXIS_TX_TREADY; AXIS_TX_TVALID = AXIS_RX_TVALID; TDATA = {zeros, RX_TDATA[0 +: RDMA_HDR_LEN*8]}; TKEEP = {REMAINING_LEN zeros, RDMA_HDR_LEN ones}.
REQ-013 On an HDR input handshake, carry_data/carry_keep SHALL load RX_TDATA/RX_TKEEP bytes [RDMA_HDR_LEN +: REMAINING_LEN].
REQ-014 HDR transitions on input handshake: TLAST=0 -> DATA; TLAST=1 and carry-in keep nonzero -> FLUSH; TLAST=1 and carry-in keep zero -> stay HDR.
REQ-015 HDR AXIS_TX_TLAST SHALL equal RX_TVALID & RX_TLAST & (RX_TKEEP[RDMA_HDR_LEN +: REMAINING_LEN]==0).
REQ-016 DATA: RX_TREADY = TX_TREADY; TX_TVALID = RX_TVALID; TDATA = {RX_TDATA[0 +: RDMA_HDR_LEN*8], carry_data}; TKEEP = {RX_TKEEP[0 +: RDMA_HDR_LEN], carry_keep}.
REQ-017 DATA handshake: carry reloads from input upper REMAINING_LEN bytes; on RX_TLAST go HDR if input upper keep is zero, else FLUSH.
REQ-018 DATA AXIS_TX_TLAST SHALL equal RX_TVALID & RX_TLAST & (RX_TKEEP[RDMA_HDR_LEN +: REMAINING_LEN]==0).
REQ-019 FLUSH: RX_TREADY=0; TX_TVALID=1; TDATA = {zeros, carry_data}; TKEEP = {zeros, carry_keep}; TLAST=1; on TX_TREADY go HDR.
REQ-020 Outside HDR/DATA/FLUSH, or when TX_TVALID=0, TDATA and TKEEP SHALL be 0.
REQ-021 Latency: zero cycles (combinational pass-through) except the FLUSH beat, one cycle after the final input beat.
REQ-022 Backpressure: TX_TREADY=0 SHALL stall input with no state or carry change; output SHALL stay stable while TVALID=1 and TREADY=0.
REQ-023 Bubbles on RX_TVALID mid-packet SHALL be tolerated with no data loss.

Reset
REQ-024 resetn low SHALL immediately (asynchronously) force state INIT, carry_data=0, carry_keep=0, all outputs per REQ-011, including mid-packet; a partial packet is discarded.
REQ-025 First input acceptance SHALL be no earlier than the second rising clk edge after resetn deasserts.

Verification
REQ-026 Header-only: 1 beat, TKEEP=51 ones, TLAST=1 -> 1 output beat, TKEEP=0x0007_FFFF_FFFF_FFFF, TLAST=1.
REQ-027 Header+5 bytes: 1 beat, TKEEP=56 ones, TLAST=1 -> header beat TLAST=0, then FLUSH beat TKEEP=0x1F, TDATA[39:0]=input bytes 51-55, TLAST=1.
REQ-028 Header+13+64+10 bytes (3 input beats, last TKEEP=0x3FF) -> 3 output beats: header; full beat with bytes 51-63 of beat0 low then bytes 0-50 of beat1; last beat TKEEP=0x7F_FFFF, TLAST=1.
REQ-029 Header+13+64+60 bytes (last TKEEP=60 ones) -> 4 output beats; 4th is FLUSH, TKEEP=0x1FF, TLAST=1.
REQ-030 Random TX_TREADY (50%) and RX_TVALID gaps over 1000 random-length packets -> output byte stream equals scoreboard reference, no loss/duplication.
REQ-031 resetn pulsed low mid-DATA -> outputs 0 during reset; next packet unpacks correctly with no residual carry bytes.
